// File: rtl/instr_decode_stage.sv
// Registered RV32I decode stage: instruction word -> control bundle, with load-use bubbles and flush.
// Optional skid entry with registered in_ready is enabled by defining DECODE_SKID_BUFFER_EN.
module instr_decode_stage #(
  parameter int XLEN             = 32,
  parameter int SRC_W            = 3,
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr_in,
  input  logic [XLEN-1:0]  pc_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  pc_out,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [2:0]       funct3,
  output logic             should_read_mem,
  output logic             should_write_mem,
  output logic             should_write_reg,
  output logic             should_branch,
  output logic             should_jump,
  output logic [SRC_W-1:0] alu_a_src,
  output logic [SRC_W-1:0] alu_b_src,
  output logic             illegal
);

  localparam logic [SRC_W-1:0] SRC_ZERO  = SRC_W'(0);
  localparam logic [SRC_W-1:0] SRC_PC    = SRC_W'(1);
  localparam logic [SRC_W-1:0] SRC_IMM_S = SRC_W'(2);
  localparam logic [SRC_W-1:0] SRC_IMM_I = SRC_W'(3);
  localparam logic [SRC_W-1:0] SRC_IMM_U = SRC_W'(4);
  localparam logic [SRC_W-1:0] SRC_IMM_B = SRC_W'(5);
  localparam logic [SRC_W-1:0] SRC_IMM_J = SRC_W'(6);
  localparam logic [SRC_W-1:0] SRC_REG   = SRC_W'(7);

  localparam logic [4:0] OP_LOAD   = 5'h00;
  localparam logic [4:0] OP_FENCE  = 5'h03;
  localparam logic [4:0] OP_IMM    = 5'h04;
  localparam logic [4:0] OP_AUIPC  = 5'h05;
  localparam logic [4:0] OP_STORE  = 5'h08;
  localparam logic [4:0] OP_OP     = 5'h0c;
  localparam logic [4:0] OP_LUI    = 5'h0d;
  localparam logic [4:0] OP_BRANCH = 5'h18;
  localparam logic [4:0] OP_JALR   = 5'h19;
  localparam logic [4:0] OP_JAL    = 5'h1b;
  localparam logic [4:0] OP_SYSTEM = 5'h1c;

  localparam logic [1:0] HCNT_INIT = 2'(LOAD_USE_BUBBLES);

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic             rd_mem;
    logic             wr_mem;
    logic             wr_reg;
    logic             branch;
    logic             jump;
    logic [SRC_W-1:0] a_src;
    logic [SRC_W-1:0] b_src;
    logic             illegal;
  } bundle_t;

  bundle_t    dec;
  bundle_t    out_q;
  bundle_t    enter_b;
  logic       out_valid_q;
  logic       enter_out;
  logic       in_fire;
  logic       reads_rs1;
  logic       reads_rs2;
  logic       hazard;
  logic [1:0] hcnt;
  logic [4:0] haz_rd;

  always_comb begin
    dec        = '0;
    dec.pc     = pc_in;
    dec.rd     = instr_in[11:7];
    dec.rs1    = instr_in[19:15];
    dec.rs2    = instr_in[24:20];
    dec.funct3 = instr_in[14:12];
    if (instr_in[1:0] != 2'b11) begin
      dec.illegal = 1'b1;
    end else begin
      case (instr_in[6:2])
        OP_LOAD:   begin dec.rd_mem = 1'b1; dec.wr_reg = 1'b1; dec.a_src = SRC_REG; dec.b_src = SRC_IMM_I; end
        OP_FENCE:  ;
        OP_IMM:    begin dec.wr_reg = 1'b1; dec.a_src = SRC_REG;  dec.b_src = SRC_IMM_I; end
        OP_AUIPC:  begin dec.wr_reg = 1'b1; dec.a_src = SRC_PC;   dec.b_src = SRC_IMM_U; end
        OP_STORE:  begin dec.wr_mem = 1'b1; dec.a_src = SRC_REG;  dec.b_src = SRC_IMM_S; end
        OP_OP:     begin dec.wr_reg = 1'b1; dec.a_src = SRC_REG;  dec.b_src = SRC_REG;   end
        OP_LUI:    begin dec.wr_reg = 1'b1; dec.a_src = SRC_ZERO; dec.b_src = SRC_IMM_U; end
        OP_BRANCH: begin dec.branch = 1'b1; dec.a_src = SRC_PC;   dec.b_src = SRC_IMM_B; end
        OP_JALR:   begin dec.wr_reg = 1'b1; dec.jump = 1'b1; dec.a_src = SRC_REG; dec.b_src = SRC_IMM_I; end
        OP_JAL:    begin dec.wr_reg = 1'b1; dec.jump = 1'b1; dec.a_src = SRC_PC;  dec.b_src = SRC_IMM_J; end
        OP_SYSTEM: ;
        default:   dec.illegal = 1'b1;
      endcase
    end
    // x0 is never a real destination, so the write strobe is suppressed for it.
    if (dec.rd == 5'd0) dec.wr_reg = 1'b0;
  end

  // Stores and branches read rs2 through a side path even though B selects an immediate.
  assign reads_rs1 = (dec.a_src == SRC_REG);
  assign reads_rs2 = (dec.b_src == SRC_REG) || dec.wr_mem || dec.branch;
  assign hazard    = (hcnt != 2'd0) &&
                     ((reads_rs1 && dec.rs1 == haz_rd) || (reads_rs2 && dec.rs2 == haz_rd));

  // Handshake: a beat moves on in_valid&&in_ready at the input and out_valid&&out_ready at the
  // output; flush and reset override both and nothing is taken or delivered in those cycles.
  assign in_fire = in_valid && in_ready;

`ifdef DECODE_SKID_BUFFER_EN
  bundle_t skid_q;
  logic    skid_valid;
  logic    ready_q;
  logic    out_free;

  assign out_free  = !out_valid_q || out_ready;
  assign in_ready  = ready_q && !reset && !flush && !hazard;
  assign enter_out = out_free && (skid_valid || in_fire);
  assign enter_b   = skid_valid ? skid_q : dec;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      skid_valid  <= 1'b0;
      skid_q      <= '0;
      ready_q     <= 1'b1;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      skid_valid  <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      if (out_free) begin
        if (skid_valid || in_fire) begin
          out_q       <= enter_b;
          out_valid_q <= 1'b1;
        end else begin
          out_valid_q <= 1'b0;
        end
        skid_valid <= 1'b0;
        ready_q    <= 1'b1;
      end else if (in_fire) begin
        // Output is stalled: park the new bundle and close the input until it drains.
        skid_q     <= dec;
        skid_valid <= 1'b1;
        ready_q    <= 1'b0;
      end
    end
  end
`else
  assign in_ready  = !reset && !flush && !hazard && (!out_valid_q || out_ready);
  assign enter_out = in_fire;
  assign enter_b   = dec;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (in_fire) begin
      out_q       <= dec;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
`endif

  // The bubble window opens when a load occupies the output register and closes after
  // LOAD_USE_BUBBLES cycles in which execute was accepting.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt   <= 2'd0;
      haz_rd <= 5'd0;
    end else if (flush) begin
      hcnt <= 2'd0;
    end else if (enter_out && enter_b.rd_mem && enter_b.rd != 5'd0) begin
      hcnt   <= HCNT_INIT;
      haz_rd <= enter_b.rd;
    end else if (out_ready && hcnt != 2'd0) begin
      hcnt <= hcnt - 2'd1;
    end
  end

  assign out_valid        = out_valid_q;
  assign pc_out           = out_q.pc;
  assign rd               = out_q.rd;
  assign rs1              = out_q.rs1;
  assign rs2              = out_q.rs2;
  assign funct3           = out_q.funct3;
  assign should_read_mem  = out_q.rd_mem;
  assign should_write_mem = out_q.wr_mem;
  assign should_write_reg = out_q.wr_reg;
  assign should_branch    = out_q.branch;
  assign should_jump      = out_q.jump;
  assign alu_a_src        = out_q.a_src;
  assign alu_b_src        = out_q.b_src;
  assign illegal          = out_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage (default build): directed cases plus a randomized stream,
// scoreboarded against a table-driven reference decoder and a simple occupancy/bubble model.
module tb_instr_decode_stage;
  localparam int XLEN = 32;
  localparam int LUB  = 1;
  localparam int W    = 62;

  logic            clk;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr_in;
  logic [XLEN-1:0] pc_in;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] pc_out;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      funct3;
  logic            should_read_mem, should_write_mem, should_write_reg, should_branch, should_jump;
  logic [2:0]      alu_a_src, alu_b_src;
  logic            illegal;

  instr_decode_stage #(.XLEN(XLEN), .SRC_W(3), .LOAD_USE_BUBBLES(LUB)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr_in(instr_in), .pc_in(pc_in),
    .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out),
    .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .should_read_mem(should_read_mem), .should_write_mem(should_write_mem),
    .should_write_reg(should_write_reg), .should_branch(should_branch),
    .should_jump(should_jump), .alu_a_src(alu_a_src), .alu_b_src(alu_b_src),
    .illegal(illegal)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] act_bundle;
  assign act_bundle = {pc_out, rd, rs1, rs2, funct3, should_read_mem, should_write_mem,
                       should_write_reg, should_branch, should_jump, alu_a_src, alu_b_src, illegal};

  int vectors    = 0;
  int miscompares = 0;

  logic [W-1:0] exp_q[$];
  logic         mon_en = 1'b0;

  // reference decoder table: legality, flags {rd_mem,wr_mem,wr_reg,branch,jump}, A, B per opcode
  logic       ref_legal [32];
  logic [4:0] ref_flags [32];
  logic [2:0] ref_a     [32];
  logic [2:0] ref_b     [32];

  // model state
  logic       m_full;
  int         m_hcnt;
  logic [4:0] m_hrd;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic set_op(input int op, input logic [4:0] fl, input logic [2:0] a, input logic [2:0] b);
    ref_legal[op] = 1'b1;
    ref_flags[op] = fl;
    ref_a[op]     = a;
    ref_b[op]     = b;
  endtask

  task automatic init_table();
    for (int i = 0; i < 32; i++) begin
      ref_legal[i] = 1'b0; ref_flags[i] = '0; ref_a[i] = '0; ref_b[i] = '0;
    end
    set_op(5'h00, 5'b10100, 3'd7, 3'd3);
    set_op(5'h03, 5'b00000, 3'd0, 3'd0);
    set_op(5'h04, 5'b00100, 3'd7, 3'd3);
    set_op(5'h05, 5'b00100, 3'd1, 3'd4);
    set_op(5'h08, 5'b01000, 3'd7, 3'd2);
    set_op(5'h0c, 5'b00100, 3'd7, 3'd7);
    set_op(5'h0d, 5'b00100, 3'd0, 3'd4);
    set_op(5'h18, 5'b00010, 3'd1, 3'd5);
    set_op(5'h19, 5'b00101, 3'd7, 3'd3);
    set_op(5'h1b, 5'b00101, 3'd1, 3'd6);
    set_op(5'h1c, 5'b00000, 3'd0, 3'd0);
  endtask

  function automatic logic ref_ok(input logic [31:0] ins);
    return (ins[1:0] == 2'b11) && ref_legal[ins[6:2]];
  endfunction

  function automatic logic [W-1:0] ref_bundle(input logic [31:0] ins, input logic [31:0] pc);
    logic [4:0] fl;
    logic [2:0] a, b;
    fl = 5'b0; a = 3'd0; b = 3'd0;
    if (ref_ok(ins)) begin
      fl = ref_flags[ins[6:2]]; a = ref_a[ins[6:2]]; b = ref_b[ins[6:2]];
    end
    if (ins[11:7] == 5'd0) fl[2] = 1'b0;
    return {pc, ins[11:7], ins[19:15], ins[24:20], ins[14:12], fl, a, b, !ref_ok(ins)};
  endfunction

  function automatic logic ref_dependent(input logic [31:0] ins, input logic [4:0] r);
    logic rd1, rd2;
    logic [4:0] fl;
    rd1 = 1'b0; rd2 = 1'b0;
    if (ref_ok(ins)) begin
      fl  = ref_flags[ins[6:2]];
      rd1 = (ref_a[ins[6:2]] == 3'd7);
      rd2 = (ref_b[ins[6:2]] == 3'd7) || fl[3] || fl[1];
    end
    return (rd1 && ins[19:15] == r) || (rd2 && ins[24:20] == r);
  endfunction

  // driver: one cycle of stimulus; checks in_ready and pushes the expected bundle on acceptance
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic fl, output logic took);
    logic exp_rdy, n_full, is_load;
    int   n_hcnt;
    logic [4:0] n_hrd;
    in_valid = v; instr_in = ins; pc_in = pc; out_ready = ordy; flush = fl;
    @(negedge clk);
    exp_rdy = !fl && !(m_hcnt > 0 && ref_dependent(ins, m_hrd)) && (!m_full || ordy);
    check("in_ready", {63'b0, in_ready}, {63'b0, exp_rdy});
    took = in_valid && in_ready;
    if (took) exp_q.push_back(ref_bundle(ins, pc));
    is_load = ref_ok(ins) && ins[6:2] == 5'h00 && ins[11:7] != 5'd0;
    n_hrd = m_hrd;
    if (fl) begin
      n_full = 1'b0; n_hcnt = 0;
    end else begin
      n_full = took || (m_full && !ordy);
      if (took && is_load) begin
        n_hcnt = LUB; n_hrd = ins[11:7];
      end else if (ordy && m_hcnt > 0) n_hcnt = m_hcnt - 1;
      else n_hcnt = m_hcnt;
    end
    @(posedge clk);
    m_full = n_full; m_hcnt = n_hcnt; m_hrd = n_hrd;
    if (fl) exp_q.delete();
    #1;
  endtask

  task automatic idle(input int n);
    logic t;
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, t);
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] pc, input logic ordy, output int stalls);
    logic took;
    stalls = 0; took = 1'b0;
    for (int i = 0; i < 20 && !took; i++) begin
      step(1'b1, ins, pc, ordy, 1'b0, took);
      if (!took) stalls++;
    end
    check("accept_timeout", {63'b0, took}, 64'd1);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; instr_in = 32'h00500093; pc_in = 32'h10; out_ready = 1'b1;
    @(negedge clk);
    check("in_ready_in_reset", {63'b0, in_ready}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; instr_in = 32'h0;
    m_full = 1'b0; m_hcnt = 0; m_hrd = 5'd0;
    exp_q.delete();
    @(negedge clk);
    check("reset_out_valid", {63'b0, out_valid}, 64'd0);
    check("reset_bundle", {2'b0, act_bundle}, 64'd0);
    @(posedge clk); #1;
    mon_en = 1'b1;
  endtask

  // monitor / scoreboard: checks occupancy and the presented bundle every cycle
  always @(negedge clk) begin
    if (mon_en) begin
      check("out_valid", {63'b0, out_valid}, {63'b0, m_full});
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_bundle", {2'b0, act_bundle}, 64'd0);
        end else begin
          check("bundle", {2'b0, act_bundle}, {2'b0, exp_q[0]});
          if (out_ready && !flush) void'(exp_q.pop_front());
        end
      end
    end
  end

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [6:0]  op;
    w = $urandom;
    case ($urandom_range(0, 9))
      0: op = 7'b0000011;
      1: op = 7'b0110011;
      2: op = 7'b0010011;
      3: op = 7'b0100011;
      4: op = 7'b1100011;
      5: op = 7'b0110111;
      6: op = 7'b1101111;
      7: op = 7'b1100111;
      8: op = 7'b0001111;
      default: return w;
    endcase
    w[6:0]   = op;
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  initial begin
    int   st;
    logic t;
    logic [31:0] pc;
    init_table();
    m_full = 1'b0; m_hcnt = 0; m_hrd = 5'd0;
    do_reset();

    // addi x0 then addi x1,x0,5 back-to-back
    offer(32'h00000013, 32'h100, 1'b1, st);
    offer(32'h00500093, 32'h104, 1'b1, st);
    idle(3);

    // load then dependent add: one bubble
    offer(32'h00012283, 32'h200, 1'b1, st);
    offer(32'h00528333, 32'h204, 1'b1, st);
    check("dep_stall_cycles", 64'(st), 64'd1);
    idle(3);

    // load then independent add: no bubble
    offer(32'h00012283, 32'h300, 1'b1, st);
    offer(32'h00108333, 32'h304, 1'b1, st);
    check("indep_stall_cycles", 64'(st), 64'd0);
    idle(3);

    // back-pressure: bundle held stable for 4 cycles, nothing else taken
    offer(32'h00500093, 32'h400, 1'b0, st);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h00108333, 32'h404, 1'b0, 1'b0, t);
    offer(32'h00108333, 32'h404, 1'b1, st);
    idle(3);

    // illegal word and store
    offer(32'hFFFFFFFF, 32'h500, 1'b1, st);
    offer(32'h00112223, 32'h504, 1'b1, st);
    idle(3);

    // flush with output held and input offered; dependent add afterwards must not stall
    offer(32'h00012283, 32'h600, 1'b0, st);
    step(1'b1, 32'h00528333, 32'h604, 1'b1, 1'b1, t);
    check("flush_took", {63'b0, t}, 64'd0);
    offer(32'h00528333, 32'h604, 1'b1, st);
    check("post_flush_stall", 64'(st), 64'd0);
    idle(3);

    // reset while a bundle is held
    offer(32'h00500093, 32'h700, 1'b0, st);
    do_reset();
    idle(2);

    // randomized stream
    pc = 32'h1000;
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, gen_instr(), pc, $urandom_range(0, 3) != 0,
           $urandom_range(0, 24) == 0, t);
      if (t) pc = pc + 4;
    end
    idle(4);
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
